// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: multi-precision adder feeding one N-bit chunk per clock through one ripple-carry adder.
// Optional subtract mode is enabled by defining MWADD_SUB_EN (adds the op_sub port).
module n_bit_ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_s,
    output logic         o_cout
);
    logic [N:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_cin;
        for (int unsigned i = 0; i < N; i++) begin
            o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c[N];
    end
endmodule

module multiword_add_sequencer #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
`ifdef MWADD_SUB_EN
    input  logic               op_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               busy
);
    localparam int W  = N * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_sum;
    logic           r_carry;
    logic           r_cout;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   w_b_chunk;
    logic [N-1:0]   w_chunk_sum;
    logic           w_chunk_cout;
    logic           w_last;
    logic           w_start_carry;

`ifdef MWADD_SUB_EN
    logic r_sub;
    assign w_b_chunk     = r_sub ? ~r_b[N-1:0] : r_b[N-1:0];
    // Subtraction is A + ~B + 1, so the incoming carry is forced to 1
    assign w_start_carry = op_sub ? 1'b1 : cin;
`else
    assign w_b_chunk     = r_b[N-1:0];
    assign w_start_carry = cin;
`endif

    n_bit_ripple_carry_adder #(.N(N)) u_adder (
        .i_a    (r_a[N-1:0]),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_s    (w_chunk_sum),
        .o_cout (w_chunk_cout)
    );

    assign w_last    = (r_cnt == CW'(WORDS - 1));
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef MWADD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_carry <= w_start_carry;
                    r_cnt   <= '0;
`ifdef MWADD_SUB_EN
                    r_sub   <= op_sub;
`endif
                end
                S_RUN: begin
                    // Chunk results enter at the MSB end so chunk 0 lands at the bottom after WORDS edges
                    r_sum   <= (r_sum >> N) | (W'(w_chunk_sum) << (W - N));
                    r_a     <= r_a >> N;
                    r_b     <= r_b >> N;
                    r_carry <= w_chunk_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) r_cout <= w_chunk_cout;
                end
                default: ;
            endcase
        end
    end
endmodule
